instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Instruction fetch stage for the MIPS CPU core. It owns the fetch PC, issues word reads to the synchronous instruction memory (1-cycle read latency), and buffers the returned instructions with their PCs in a small prefetch queue. The queue feeds the decode/control stage through a valid/ready handshake. Branch and jump targets resolved downstream redirect fetch and flush all buffered and in-flight work.

## Interface
- DEPTH, 4: prefetch queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000: fetch PC loaded on reset.
- CLK  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  read request this cycle.
- imem_addr  out  32  byte address of request; bits [1:0] always 0.
- imem_rdata  in  32  instruction word, valid exactly one cycle after imem_req.
- redirect  in  1  taken branch/jump from execute; one-cycle pulse.
- redirect_pc  in  32  new fetch target; bits [1:0] ignored (treated as 0).
- inst_valid  out  1  queue head holds a valid instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_data  out  32  head instruction word.
- inst_pc  out  32  byte address of head instruction.
- inst_pc_plus4  out  32  inst_pc + 4, modulo 2^32.

## Operation
- State: fetch_pc (32b), inflight flag plus inflight_pc, queue count (0..DEPTH), read/write pointers.
- Issue: imem_req=1 when not rst, not redirect, and count + inflight − pop < DEPTH, where pop = inst_valid & inst_ready. On issue: imem_addr=fetch_pc, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps 32'hFFFF_FFFC→0).
- Response: cycle after an issue, {inflight_pc, imem_rdata} written at queue tail unless killed.
- Pop: head advances on inst_valid & inst_ready.
- Push and pop in the same cycle: count unchanged; allowed when full (credit guarantees no overflow).
- Redirect: queue flushed (count<=0, pointers reset), any in-flight response killed (not written), fetch_pc<=redirect_pc & ~3; no issue in the redirect cycle. A pop in the same cycle counts as accepted by decode. First request to the new target occurs the next cycle.
- Redirect while queue empty and nothing in flight: same behaviour, no spurious writes.
- Overflow and underflow are impossible by construction; assertions check count ≤ DEPTH and that no write occurs when full without a pop.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=RESET_PC, inst_pc_plus4=RESET_PC+4; count=0, inflight=0, fetch_pc=RESET_PC.
- rst asserted mid-operation overrides redirect and handshake; contents are discarded and the in-flight response is dropped.
- Latency without bypass: request in cycle T, data written at end of T+1, inst_valid in T+2 (cycle 0 = first cycle after rst deasserts → first valid in cycle 2).
- Redirect in cycle R: first instruction from the target is valid in R+3 (R+2 with bypass).
- Throughput: one instruction per cycle sustained with inst_ready held high, for DEPTH ≥ 2.
- Outputs are driven from registered queue storage, except in the bypass path.

## Configuration
- FETCH_BYPASS_EN defined: when the queue is empty and a non-killed response arrives, the response drives inst_valid/inst_data/inst_pc combinationally in the same cycle. If inst_ready=1 in that cycle, the entry is not written to the queue. This reduces latency by one cycle.
- Undefined: every response passes through the queue; outputs are purely registered.

## Structure
- Package fetch_pkg: FETCH_RESET_PC default, INST_W=32, ADDR_W=32, typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo: synchronous DEPTH×fetch_entry_t FIFO with push, pop, flush, count, full, empty. The top level holds the PC, credit, kill, and bypass logic.

## Test plan
- Reset, then inst_ready=1 constantly, with the memory returning word = address: inst_valid rises in cycle 2; inst_pc = 0, 4, 8, … on consecutive cycles with inst_data matching.
- inst_ready=0 for 10 cycles: exactly DEPTH=4 entries are buffered and imem_req drops. Releasing ready yields PCs 0, 4, 8, 12, 16 back-to-back with no gap.
- redirect with redirect_pc=32'h40 while the queue is full and a request is in flight: the next valid is inst_pc=0x40 in R+3, and no stale PC appears.
- redirect_pc=32'h43: imem_addr=0x40 and inst_pc=0x40.
- fetch_pc=32'hFFFF_FFFC: the next issue is at address 0; inst_pc_plus4 of the last word is 0.
- rst asserted while 3 entries are queued: the next cycle has inst_valid=0 and imem_addr=RESET_PC. With FETCH_BYPASS_EN defined, the first valid arrives in cycle 1 instead of 2.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue and its prefetch FIFO.
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & {{(ADDR_W-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {pc, instr}, head visible combinationally from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [ENTRY_W-1:0]     push_data,
  input  logic                   pop,
  output logic [ENTRY_W-1:0]     head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               do_push;
  logic               do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign count     = count_reg;
  assign head_data = mem[rd_ptr_reg];
  assign do_pop    = pop & ~empty;
  // A push into a full queue is only legal alongside a pop that frees the slot.
  assign do_push   = push & (~full | do_pop);

  always_ff @(posedge CLK) begin
    if (rst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (!rst) assert (count_reg <= CNT_W'(DEPTH));
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues imem reads under queue credit, buffers responses.
// Define FETCH_BYPASS_EN to forward a response to decode in its arrival cycle when the queue is empty.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        CLK,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [31:0]        fetch_pc_reg;
  logic [31:0]        inflight_pc_reg;
  logic               inflight_reg;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head_bits;
  fetch_entry_t       resp_entry;
  fetch_entry_t       head_entry;
  logic               resp_live;
  logic               bypass;
  logic               pop;
  logic               push;
  logic [OCC_W-1:0]   occ;
  logic [OCC_W-1:0]   limit;

  // A response landing in a redirect or reset cycle belongs to the old stream.
  assign resp_live  = inflight_reg & ~redirect & ~rst;
  assign resp_entry = '{pc: inflight_pc_reg, instr: imem_rdata};

`ifdef FETCH_BYPASS_EN
  assign bypass = fifo_empty & resp_live;
`else
  assign bypass = 1'b0;
`endif

  assign head_entry    = bypass ? resp_entry : fetch_entry_t'(head_bits);
  assign inst_valid    = ~rst & (~fifo_empty | bypass);
  assign inst_data     = inst_valid ? head_entry.instr : '0;
  assign inst_pc       = inst_valid ? head_entry.pc : RESET_PC;
  assign inst_pc_plus4 = inst_pc + 32'd4;

  assign pop  = inst_valid & inst_ready;
  assign push = resp_live & ~(bypass & inst_ready);

  // Credit: queued entries plus the outstanding read must leave room after this cycle's pop.
  assign occ      = OCC_W'(fifo_count) + OCC_W'(inflight_reg);
  assign limit    = OCC_W'(DEPTH) + OCC_W'(pop);
  assign imem_req = ~rst & ~redirect & (occ < limit);
  assign imem_addr = rst ? RESET_PC : fetch_pc_reg;

  always_ff @(posedge CLK) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_reg <= word_align(redirect_pc);
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= imem_req;
      if (imem_req) begin
        inflight_pc_reg <= fetch_pc_reg;
        fetch_pc_reg    <= fetch_pc_reg + 32'd4;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst) assert (!(push && fifo_full && !pop));
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (resp_entry),
    .pop       (pop),
    .head_data (head_bits),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_LAT = 1;
  localparam int REDIR_LAT = 2;
  localparam bit BYP       = 1'b1;
`else
  localparam int FIRST_LAT = 2;
  localparam int REDIR_LAT = 3;
  localparam bit BYP       = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] mem_xor = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  // Instruction memory: word at address a is a ^ mem_xor, one-cycle read latency.
  always @(posedge CLK) imem_rdata <= imem_addr ^ mem_xor;

  instr_fetch_queue #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .CLK          (CLK),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_data    (inst_data),
    .inst_pc      (inst_pc),
    .inst_pc_plus4(inst_pc_plus4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: an ordered list of fetched-but-unconsumed words plus one outstanding read.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_ie;
  ent_t        m_head;
  logic [31:0] m_fpc = RESET_PC;
  bit          m_infl = 1'b0;
  bit          m_byp, m_ev, m_pop, m_req;
  int          m_occ;

  initial begin
    forever begin
      @(negedge CLK);
      if (rst) begin
        chk("req_in_reset", 32'(imem_req), 32'd0);
        mq.delete();
        m_infl = 1'b0;
        m_fpc  = RESET_PC;
      end else begin
        m_byp  = BYP && (mq.size() == 0) && m_infl && !redirect;
        m_ev   = (mq.size() > 0) || m_byp;
        m_head = (mq.size() > 0) ? mq[0] : m_ie;
        m_pop  = m_ev && inst_ready;
        m_occ  = mq.size() + (m_infl ? 1 : 0) - (m_pop ? 1 : 0);
        m_req  = !redirect && (m_occ < DEPTH);
        chk("inst_valid", 32'(inst_valid), 32'(m_ev));
        if (m_ev) begin
          chk("inst_pc", inst_pc, m_head.pc);
          chk("inst_data", inst_data, m_head.data);
          chk("inst_pc_plus4", inst_pc_plus4, m_head.pc + 32'd4);
        end
        chk("imem_req", 32'(imem_req), 32'(m_req));
        chk("imem_addr", imem_addr, m_fpc);
        if (redirect) begin
          mq.delete();
          m_infl = 1'b0;
          m_fpc  = redirect_pc & 32'hFFFF_FFFC;
        end else begin
          if (m_pop && !m_byp) void'(mq.pop_front());
          if (m_infl && !(m_byp && inst_ready)) mq.push_back(m_ie);
          m_infl = m_req;
          if (m_req) begin
            m_ie.pc   = m_fpc;
            m_ie.data = m_fpc ^ mem_xor;
            m_fpc     = m_fpc + 32'd4;
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input bit ready);
    rst        = 1'b1;
    redirect   = 1'b0;
    inst_ready = ready;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    bit found;
    int thr;

    // Reset values, then streaming with decode always ready.
    rst = 1'b1;
    inst_ready = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", inst_pc, RESET_PC);
    chk("rst_pc_plus4", inst_pc_plus4, RESET_PC + 32'd4);
    chk("rst_addr", imem_addr, RESET_PC);
    next_cycle();
    rst = 1'b0;
    first = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (inst_valid) begin
        first = c;
        break;
      end
      next_cycle();
    end
    chk("first_valid_cycle", 32'(first), 32'(FIRST_LAT));
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        next_cycle();
        @(negedge CLK);
      end
      chk("stream_valid", 32'(inst_valid), 32'd1);
      chk("stream_pc", inst_pc, 32'(4 * k));
      chk("stream_data", inst_data, 32'(4 * k));
    end

    // Stall decode for 10 cycles, then drain back-to-back.
    next_cycle();
    do_reset(1'b0);
    repeat (9) next_cycle();
    @(negedge CLK);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_valid", 32'(inst_valid), 32'd1);
    chk("stall_pc", inst_pc, 32'd0);
    next_cycle();
    inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("drain_valid", 32'(inst_valid), 32'd1);
      chk("drain_pc", inst_pc, 32'(4 * k));
      next_cycle();
    end

    // Redirect to an unaligned target while entries are queued and a read is outstanding.
    do_reset(1'b0);
    repeat (4) next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0043;
    @(negedge CLK);
    chk("pre_redir_pc", inst_pc, 32'd0);
    next_cycle();
    redirect = 1'b0;
    @(negedge CLK);
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h0000_0040);
    chk("redir_no_stale", 32'(inst_valid), 32'd0);
    for (int d = 2; d <= REDIR_LAT; d++) begin
      next_cycle();
      @(negedge CLK);
      if (d < REDIR_LAT) begin
        chk("redir_gap_valid", 32'(inst_valid), 32'd0);
      end else begin
        chk("redir_valid", 32'(inst_valid), 32'd1);
        chk("redir_pc", inst_pc, 32'h0000_0040);
        chk("redir_data", inst_data, 32'h0000_0040);
      end
    end

    // PC wrap at the top of the address space.
    next_cycle();
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    next_cycle();
    redirect = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (inst_valid) begin
        found = 1'b1;
        break;
      end
      next_cycle();
    end
    chk("wrap_found", 32'(found), 32'd1);
    chk("wrap_pc0", inst_pc, 32'hFFFF_FFF8);
    next_cycle();
    @(negedge CLK);
    chk("wrap_pc1", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", inst_pc_plus4, 32'd0);
    next_cycle();
    @(negedge CLK);
    chk("wrap_pc2", inst_pc, 32'd0);
    chk("wrap_pc2_plus4", inst_pc_plus4, 32'd4);

    // Reset while three entries are queued.
    next_cycle();
    do_reset(1'b0);
    repeat (4) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge CLK);
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_addr", imem_addr, RESET_PC);
    first = -1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        next_cycle();
        @(negedge CLK);
      end
      if (inst_valid) begin
        first = c;
        break;
      end
    end
    chk("midrst_first_valid", 32'(first), 32'(FIRST_LAT));

    // Randomized traffic: varying decode back-pressure, redirects and occasional resets.
    next_cycle();
    mem_xor = $urandom;
    do_reset(1'b1);
    for (int i = 0; i < 3000; i++) begin
      thr         = (i / 200) % 4;
      rst         = ($urandom_range(0, 199) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      inst_ready  = ($urandom_range(0, 3) >= thr);
      next_cycle();
    end
    rst      = 1'b0;
    redirect = 1'b0;
    next_cycle();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
